// File: rtl/rele_bank_ctrl_if.sv
// Relay-bank request/drive bundle: per-channel en/clr requests in, relay drive and dwell status out.
// Latency: none (wires only); the controller registers out/busy one cycle after the sampled request.
// Backpressure: none; requests are level-sampled every cycle, and busy reports dwell status only.
//
// Ports (signals):
//   en   [N_CH]  turn-on request per channel, driven by master
//   clr  [N_CH]  turn-off request per channel, driven by master, wins over en
//   out  [N_CH]  relay drive, 1 = relay closed, driven by slave
//   busy [N_CH]  channel is inside a minimum-on/off dwell, driven by slave
interface rele_bank_ctrl_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] busy;

    modport master (
        output en,
        output clr,
        input  out,
        input  busy
    );

    modport slave (
        input  en,
        input  clr,
        output out,
        output busy
    );
endinterface

// File: rtl/rele_bank_ctrl.sv
// Multi-channel relay controller with per-channel minimum-on/minimum-off dwell (anti-short-cycle).
// Latency: out/busy are registered and follow a sampled request by one cycle.
// Backpressure: none; requests seen during a dwell are held as a pending bit and applied at dwell end.
//
// Ports: clk (rising edge), rst (async, active low), bus (rele_bank_ctrl_if.slave: en, clr, out, busy).
// Optional build macro RELE_INTERLOCK_EN: at most one relay closed at a time; when several
// channels try to close in the same cycle, the lowest index wins and the rest retry each cycle.
module rele_bank_ctrl #(
    parameter int N_CH    = 4,
    parameter int MIN_ON  = 16,
    parameter int MIN_OFF = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    rele_bank_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON_HOLD  = 2'd1,
        ST_ON       = 2'd2,
        ST_OFF_HOLD = 2'd3
    } state_t;

    // Timers count down to zero, so a dwell of N cycles loads N-1.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] timer_q [N_CH];
    logic [CNT_W-1:0] timer_d [N_CH];
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  out_q, out_d;
    logic [N_CH-1:0]  busy_q, busy_d;

    logic [N_CH-1:0]  set_req;   // en without clr: clr always dominates
    logic [N_CH-1:0]  pend_upd;  // pending bit after this cycle's request is folded in
    logic [N_CH-1:0]  want;      // channel is trying to close its relay this cycle
    logic [N_CH-1:0]  grant;     // permission to close the relay this cycle

    // Pending update and close-request detection. The dwell-end decision uses the
    // updated pending bit so a request sampled on the last dwell cycle still counts.
    always_comb begin
        set_req  = '0;
        pend_upd = '0;
        want     = '0;
        for (int i = 0; i < N_CH; i++) begin
            set_req[i] = bus.en[i] & ~bus.clr[i];
            case (state_q[i])
                ST_ON_HOLD: begin
                    if (bus.clr[i])      pend_upd[i] = 1'b1;
                    else if (set_req[i]) pend_upd[i] = 1'b0;
                    else                 pend_upd[i] = pend_q[i];
                end
                ST_OFF_HOLD: begin
                    if (bus.clr[i])      pend_upd[i] = 1'b0;
                    else if (set_req[i]) pend_upd[i] = 1'b1;
                    else                 pend_upd[i] = pend_q[i];
                end
                default: pend_upd[i] = 1'b0;
            endcase
            want[i] = ((state_q[i] == ST_OFF) && set_req[i]) ||
                      ((state_q[i] == ST_OFF_HOLD) && (timer_q[i] == '0) && pend_upd[i]);
        end
    end

`ifdef RELE_INTERLOCK_EN
    // A channel may close only while every other relay is open; among those that
    // qualify in the same cycle, the lowest index is granted.
    always_comb begin
        logic [N_CH-1:0] others;
        logic            taken;
        grant  = '0;
        others = '0;
        taken  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            others    = out_q;
            others[i] = 1'b0;
            if (want[i] && (others == '0) && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = want;
    end
`endif

    // Per-channel next-state logic.
    always_comb begin
        pend_d = pend_upd;
        out_d  = '0;
        busy_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (grant[i]) begin
                        state_d[i] = ST_ON_HOLD;
                        timer_d[i] = ON_LOAD;
                    end
                end
                ST_ON_HOLD: begin
                    if (timer_q[i] != '0) begin
                        timer_d[i] = timer_q[i] - CNT_ONE;
                    end else if (pend_upd[i]) begin
                        state_d[i] = ST_OFF_HOLD;
                        timer_d[i] = OFF_LOAD;
                        pend_d[i]  = 1'b0;
                    end else begin
                        state_d[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (bus.clr[i]) begin
                        state_d[i] = ST_OFF_HOLD;
                        timer_d[i] = OFF_LOAD;
                    end
                end
                ST_OFF_HOLD: begin
                    if (timer_q[i] != '0) begin
                        timer_d[i] = timer_q[i] - CNT_ONE;
                    end else if (pend_upd[i]) begin
                        // Without a grant the channel parks here with timer at 0
                        // and pending kept, retrying every cycle.
                        if (grant[i]) begin
                            state_d[i] = ST_ON_HOLD;
                            timer_d[i] = ON_LOAD;
                            pend_d[i]  = 1'b0;
                        end
                    end else begin
                        state_d[i] = ST_OFF;
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    timer_d[i] = '0;
                    pend_d[i]  = 1'b0;
                end
            endcase
            out_d[i]  = (state_d[i] == ST_ON_HOLD) || (state_d[i] == ST_ON);
            busy_d[i] = (state_d[i] == ST_ON_HOLD) || (state_d[i] == ST_OFF_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_OFF;
                timer_q[i] <= '0;
            end
            pend_q <= '0;
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            pend_q <= pend_d;
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_rele_bank_ctrl.sv
// Bench for rele_bank_ctrl with N_CH=2, MIN_ON=4, MIN_OFF=3 and directed request vectors.
// Latency: each vector is applied on a falling edge; its expected out/busy are due one cycle later.
// Backpressure: none; expected responses are queued by cycle and popped by an independent monitor.
module tb_rele_bank_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;

    int         q_cyc[$];
    logic [1:0] q_out[$];
    logic [1:0] q_busy[$];
    string      q_nm[$];

    rele_bank_ctrl_if #(.N_CH(2)) bus ();

    rele_bank_ctrl #(
        .N_CH    (2),
        .MIN_ON  (4),
        .MIN_OFF (3),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Apply one vector and queue the out/busy expected after the next rising edge.
    task automatic step(input logic r, input logic [1:0] e, input logic [1:0] c,
                        input logic [1:0] eo, input logic [1:0] eb, input string nm);
        @(negedge clk);
        rst     = r;
        bus.en  = e;
        bus.clr = c;
        q_cyc.push_back(cyc + 1);
        q_out.push_back(eo);
        q_busy.push_back(eb);
        q_nm.push_back(nm);
    endtask

    // Monitor: compares every due expectation against the DUT, decoupled from stimulus.
    initial begin
        n_chk  = 0;
        n_pass = 0;
        forever begin
            @(negedge clk);
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                int         c_due;
                logic [1:0] e_out;
                logic [1:0] e_busy;
                string      nm;
                c_due  = q_cyc.pop_front();
                e_out  = q_out.pop_front();
                e_busy = q_busy.pop_front();
                nm     = q_nm.pop_front();
                n_chk++;
                if (bus.out === e_out && bus.busy === e_busy && c_due == cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d: out=%b busy=%b, expected out=%b busy=%b (due cyc %0d)",
                             nm, cyc, bus.out, bus.busy, e_out, e_busy, c_due);
                end
            end
`ifdef RELE_INTERLOCK_EN
            n_chk++;
            if (bus.out !== 2'b11) begin
                n_pass++;
            end else begin
                $display("FAIL interlock cyc=%0d: out=%b, expected not 11", cyc, bus.out);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        bus.en  = 2'b11;
        bus.clr = 2'b00;

        // Reset holds everything off even with requests present.
        step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, "rst_hold0");
        step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, "rst_hold1");
`ifdef RELE_INTERLOCK_EN
        step(1'b1, 2'b11, 2'b00, 2'b01, 2'b01, "rst_release");
        // ch1 retries while ch0 dwells; ch0 is cleared and ch1 closes once out[0]=0.
        step(1'b1, 2'b10, 2'b01, 2'b01, 2'b01, "il_blk0");
        step(1'b1, 2'b10, 2'b01, 2'b01, 2'b01, "il_blk1");
        step(1'b1, 2'b10, 2'b01, 2'b01, 2'b01, "il_blk2");
        step(1'b1, 2'b10, 2'b01, 2'b00, 2'b01, "il_ch0_fall");
        step(1'b1, 2'b10, 2'b01, 2'b10, 2'b11, "il_ch1_rise");
        // ch0 re-requests in OFF_HOLD and must wait for ch1 to open.
        step(1'b1, 2'b01, 2'b00, 2'b10, 2'b11, "il_ch0_pend");
        step(1'b1, 2'b00, 2'b00, 2'b10, 2'b11, "il_ch0_park0");
        step(1'b1, 2'b00, 2'b00, 2'b10, 2'b11, "il_ch0_park1");
        step(1'b1, 2'b00, 2'b00, 2'b10, 2'b01, "il_ch1_on");
        step(1'b1, 2'b00, 2'b10, 2'b00, 2'b11, "il_ch1_fall");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b11, "il_ch0_grant");
`else
        step(1'b1, 2'b11, 2'b00, 2'b11, 2'b11, "rst_release");
        step(1'b1, 2'b00, 2'b00, 2'b11, 2'b11, "both_hold");
`endif
        // Reset mid-dwell aborts immediately.
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "rst_abort");

        // Minimum-on: 1-cycle en, then clr held.
        step(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, "mo_set");
        step(1'b1, 2'b00, 2'b01, 2'b01, 2'b01, "mo_hold1");
        step(1'b1, 2'b00, 2'b01, 2'b01, 2'b01, "mo_hold2");
        step(1'b1, 2'b00, 2'b01, 2'b01, 2'b01, "mo_hold3");
        step(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, "mo_fall");
        step(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, "mo_offhold1");
        step(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, "mo_offhold2");
        step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, "mo_off");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, "mo_idle");

        // Pending cancel in ON_HOLD: clr then en, dwell ends in ON.
        step(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, "pc_set");
        step(1'b1, 2'b00, 2'b01, 2'b01, 2'b01, "pc_clr");
        step(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, "pc_cancel");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, "pc_last");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, "pc_on");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, "pc_on_stay");

        // en=clr=1 in ON acts as clr.
        step(1'b1, 2'b01, 2'b01, 2'b00, 2'b01, "sim_on_fall");

        // Re-request in OFF_HOLD: out returns 3 cycles after it fell.
        step(1'b1, 2'b01, 2'b00, 2'b00, 2'b01, "rr_req");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, "rr_wait");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, "rr_rise");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, "rr_hold1");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, "rr_hold2");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, "rr_hold3");
        step(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, "rr_on");
        step(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, "rr_clr");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, "rr_off1");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, "rr_off2");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, "rr_off");

        // en=clr=1 in OFF keeps both channels open.
        step(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, "sim_off");
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, "sim_off_idle");

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && q_cyc.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q_cyc.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", q_cyc.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rele_bank_ctrl.md
Name: rele_bank_ctrl

Overview:
- Parametrised, multi-channel successor of the single relay FSM.
- Each channel drives one relay output from set (en) and clear (clr) requests.
- Enforces a minimum-on and minimum-off dwell time per channel (compressor/boiler anti-short-cycle).
- Requests arriving during a dwell are held as pending and applied when the dwell expires. Sits between the thermostat decision logic and the relay driver pins.

Parameters:
- N_CH, 4, number of independent relay channels (>=1).
- MIN_ON, 16, minimum cycles out[i] stays 1 once asserted (1 .. 2^CNT_W-1).
- MIN_OFF, 16, minimum cycles out[i] stays 0 once deasserted (1 .. 2^CNT_W-1).
- CNT_W, 8, width of each per-channel dwell timer.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  N_CH  per-channel turn-on request, level-sampled.
- clr  input  N_CH  per-channel turn-off request, level-sampled; priority over en.
- out  output  N_CH  relay drive, 1 = relay closed.
- busy  output  N_CH  1 while the channel is in a dwell (ON_HOLD/OFF_HOLD).

Behaviour:
- Reset (rst=0, async): all channels go to OFF; out=0, busy=0, timers=0, pending=0. Reset asserted mid-dwell aborts the dwell immediately.
- Per-channel FSM with states OFF, ON_HOLD, ON, OFF_HOLD, plus a pending bit and a CNT_W timer. Channels are fully independent unless the interlock is enabled.
- OFF: en=1 & clr=0 moves to ON_HOLD, loads timer=MIN_ON-1, and sets out=1 from the next cycle (1-cycle latency). Otherwise the channel stays in OFF.
- ON_HOLD: out=1, busy=1, timer decrements each cycle.
  - clr=1 sets pending.
  - en=1 & clr=0 clears pending (latest request wins).
  - At timer==0: if pending (including clr sampled that same cycle), go to OFF_HOLD, load MIN_OFF-1, clear pending; else go to ON.
  - Result: out is high for exactly MIN_ON cycles when clr is held continuously.
- ON: out=1, busy=0. clr=1 moves to OFF_HOLD and loads timer=MIN_OFF-1; out=0 from the next cycle. en is ignored.
- OFF_HOLD: out=0, busy=1, timer decrements.
  - en=1 & clr=0 sets pending.
  - clr=1 clears pending.
  - At timer==0: if pending, go to ON_HOLD, load MIN_ON-1, clear pending; else go to OFF.
- en=clr=1 in the same cycle is treated as clr in every state.
- Timer never wraps. It is only loaded on state entry and only decremented while nonzero in a hold state.
- MIN_ON=1 or MIN_OFF=1 gives a 1-cycle hold, which degenerates to the plain set/clear FSM behaviour.
- All outputs are registered; no combinational path from en/clr to out.

Optional Feature:
- Macro: RELE_INTERLOCK_EN.
- Defined:
  - A channel may leave OFF, or leave OFF_HOLD with pending, only if out of every other channel is 0 in that cycle.
  - If several channels qualify in the same cycle, only the lowest index is granted. The others remain in OFF, or keep pending in OFF_HOLD with the timer held at 0, and retry each cycle.
  - Guarantees at most one out bit high (heat/cool mutual exclusion).
- Undefined: no cross-channel logic; channels are independent as above.

Test Plan:
- Reset: with N_CH=2, MIN_ON=4, MIN_OFF=3, hold rst=0 with en=2'b11 -> out=00, busy=00. Release rst on a negedge -> out=11 one cycle after the first rising edge.
- Min-on: ch0 en pulse for 1 cycle, then clr=1 held -> out[0]=1 for exactly 4 cycles, then 0; busy[0]=1 for 4 cycles, then 3 more cycles in OFF_HOLD.
- Pending cancel: in ON_HOLD, clr=1 at cycle 1, en=1 & clr=0 at cycle 2 -> at dwell end ch0 goes to ON, out[0] stays 1.
- Off-hold re-request: in OFF_HOLD, en=1 for one cycle -> out[0] returns to 1 exactly 3 cycles after it fell.
- Simultaneous en=clr=1 in OFF -> out stays 0. In ON -> out falls next cycle.
- RELE_INTERLOCK_EN defined: en=2'b11 from OFF -> only out[0]=1. After ch0 completes min-on, then clr and OFF_HOLD, out[1] rises on the first cycle where out[0]=0. out==2'b11 is never observed.
